// File: rtl/bsg_two_fifo_bypass_pkg.sv
// Shared types for the two-entry bypass FIFO: occupancy encoding.
package bsg_two_fifo_bypass_pkg;
  typedef logic [1:0] count_t;
  localparam count_t CNT_EMPTY = 2'd0;
  localparam count_t CNT_FULL  = 2'd2;
endpackage

// File: rtl/bsg_two_fifo_bypass_if.sv
// Producer/consumer handshake bundle for the two-entry bypass FIFO.
interface bsg_two_fifo_bypass_if #(parameter int width_p = 32);
  logic               valid_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport slave  (input valid_i, data_i, yumi_i, output ready_o, v_o, data_o);
  modport master (output valid_i, data_i, yumi_i, input ready_o, v_o, data_o);
endinterface

// File: rtl/bsg_two_fifo_bypass_mem.sv
// 2 x width_p storage, synchronous write, asynchronous read; contents not reset.
module bsg_two_fifo_bypass_mem #(parameter int width_p = 32) (
  input  logic               clk_i,
  input  logic               w_v_i,
  input  logic               w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               r_addr_i,
  output logic [width_p-1:0] r_data_o
);
  logic [width_p-1:0] mem [2];

  always_ff @(posedge clk_i)
    if (w_v_i) mem[w_addr_i] <= w_data_i;

  assign r_data_o = mem[r_addr_i];
endmodule

// File: rtl/bsg_two_fifo_bypass.sv
// Two-entry valid/ready FIFO; when empty, data_i passes straight to data_o
// in the same cycle (bypass_en_p=1) so the downstream stage sees zero latency.
module bsg_two_fifo_bypass
  import bsg_two_fifo_bypass_pkg::*;
#(
  parameter int width_p     = 32,
  parameter bit bypass_en_p = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bsg_two_fifo_bypass_if.slave link
);
  count_t             count_r;
  logic               rd_ptr_r, wr_ptr_r;
  logic               enq, bypass, wr_v, rd_v;
  logic [width_p-1:0] head;

  assign bypass       = bypass_en_p && (count_r == CNT_EMPTY);
  assign link.ready_o = (count_r != CNT_FULL) & ~reset_i;
  assign link.v_o     = (count_r != CNT_EMPTY) | (bypass_en_p & link.valid_i & ~reset_i);
  assign link.data_o  = bypass ? link.data_i : head;

  // A word bypassed and consumed in the same cycle never touches storage.
  assign enq  = link.valid_i & link.ready_o;
  assign wr_v = enq & ~(bypass & link.yumi_i);
  assign rd_v = link.yumi_i & (count_r != CNT_EMPTY);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r  <= CNT_EMPTY;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (wr_v) wr_ptr_r <= ~wr_ptr_r;
      if (rd_v) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + count_t'(wr_v) - count_t'(rd_v);
    end
  end

  bsg_two_fifo_bypass_mem #(.width_p(width_p)) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (wr_v),
    .w_addr_i (wr_ptr_r),
    .w_data_i (link.data_i),
    .r_addr_i (rd_ptr_r),
    .r_data_o (head)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(link.yumi_i && !link.v_o)) else $error("yumi_i asserted without v_o");
      assert (count_r <= CNT_FULL) else $error("count_r out of range");
    end
  end
`endif
endmodule

// File: tb/tb_bsg_two_fifo_bypass.sv
// Directed scenarios plus a random soak against a reference queue, for both
// the bypassing and the registered-output variant.
module tb_bsg_two_fifo_bypass;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  bsg_two_fifo_bypass_if #(.width_p(32)) ifa ();
  bsg_two_fifo_bypass_if #(.width_p(32)) ifb ();

  bsg_two_fifo_bypass #(.width_p(32), .bypass_en_p(1'b1)) dut_a (
    .clk_i(clk), .reset_i(rst), .link(ifa.slave));
  bsg_two_fifo_bypass #(.width_p(32), .bypass_en_p(1'b0)) dut_b (
    .clk_i(clk), .reset_i(rst), .link(ifb.slave));

  task automatic drv_a(input logic v, input logic [31:0] d, input logic y);
    @(negedge clk);
    ifa.valid_i = v; ifa.data_i = d; ifa.yumi_i = y;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drv_a(1'b1, 32'hDEAD_BEEF, 1'b0);
    n_cmp++; if (ifa.v_o !== 1'b0) begin n_bad++; $display("FAIL rst_v got=%b exp=0", ifa.v_o); end
    n_cmp++; if (ifa.ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", ifa.ready_o); end
    n_cmp++; if (ifb.ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready_b got=%b exp=0", ifb.ready_o); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (ifa.ready_o !== 1'b1) begin n_bad++; $display("FAIL rel_ready got=%b exp=1", ifa.ready_o); end
    n_cmp++; if (ifa.v_o !== 1'b1) begin n_bad++; $display("FAIL rel_v got=%b exp=1", ifa.v_o); end
    n_cmp++; if (ifa.data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rel_data got=%h exp=deadbeef", ifa.data_o); end
    ifa.yumi_i = 1'b1;
    drv_a(1'b0, 32'h0, 1'b0);
    n_cmp++; if (ifa.v_o !== 1'b0) begin n_bad++; $display("FAIL rel_drain_v got=%b exp=0", ifa.v_o); end
  endtask

  task automatic test_bypass;
    for (int i = 1; i <= 4; i++) begin
      drv_a(1'b1, 32'(i), 1'b1);
      n_cmp++; if (ifa.v_o !== 1'b1 || ifa.data_o !== 32'(i)) begin
        n_bad++; $display("FAIL bypass_%0d got v=%b d=%h exp v=1 d=%h", i, ifa.v_o, ifa.data_o, i);
      end
    end
    drv_a(1'b0, 32'h0, 1'b0);
    n_cmp++; if (ifa.v_o !== 1'b0) begin n_bad++; $display("FAIL bypass_empty got v=%b exp=0", ifa.v_o); end
  endtask

  task automatic test_fill_stall;
    drv_a(1'b1, 32'hA, 1'b0);
    drv_a(1'b1, 32'hB, 1'b0);
    drv_a(1'b1, 32'h33, 1'b0);
    n_cmp++; if (ifa.ready_o !== 1'b0 || ifa.v_o !== 1'b1 || ifa.data_o !== 32'hA) begin
      n_bad++; $display("FAIL full got r=%b v=%b d=%h exp r=0 v=1 d=a", ifa.ready_o, ifa.v_o, ifa.data_o);
    end
    drv_a(1'b0, 32'h0, 1'b1);
    n_cmp++; if (ifa.data_o !== 32'hA) begin n_bad++; $display("FAIL drain1 got=%h exp=a", ifa.data_o); end
    drv_a(1'b0, 32'h0, 1'b1);
    n_cmp++; if (ifa.data_o !== 32'hB || ifa.ready_o !== 1'b1) begin
      n_bad++; $display("FAIL drain2 got d=%h r=%b exp d=b r=1", ifa.data_o, ifa.ready_o);
    end
    drv_a(1'b0, 32'h0, 1'b0);
    n_cmp++; if (ifa.v_o !== 1'b0) begin n_bad++; $display("FAIL third_dropped got v=%b exp=0", ifa.v_o); end
  endtask

  task automatic test_simul_one;
    drv_a(1'b1, 32'hA, 1'b0);
    drv_a(1'b1, 32'hC, 1'b1);
    n_cmp++; if (ifa.data_o !== 32'hA || ifa.ready_o !== 1'b1) begin
      n_bad++; $display("FAIL simul_head got d=%h r=%b exp d=a r=1", ifa.data_o, ifa.ready_o);
    end
    drv_a(1'b0, 32'h0, 1'b1);
    n_cmp++; if (ifa.v_o !== 1'b1 || ifa.data_o !== 32'hC) begin
      n_bad++; $display("FAIL simul_next got v=%b d=%h exp v=1 d=c", ifa.v_o, ifa.data_o);
    end
    drv_a(1'b0, 32'h0, 1'b0);
    n_cmp++; if (ifa.v_o !== 1'b0) begin n_bad++; $display("FAIL simul_empty got v=%b exp=0", ifa.v_o); end
  endtask

  task automatic test_reset_mid;
    drv_a(1'b1, 32'hA, 1'b0);
    drv_a(1'b1, 32'hB, 1'b0);
    drv_a(1'b0, 32'h0, 1'b0);
    rst = 1'b1; #1;
    n_cmp++; if (ifa.v_o !== 1'b0 || ifa.ready_o !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst got v=%b r=%b exp v=0 r=0", ifa.v_o, ifa.ready_o);
    end
    #2 rst = 1'b0;
    drv_a(1'b0, 32'h0, 1'b0);
    n_cmp++; if (ifa.v_o !== 1'b0) begin n_bad++; $display("FAIL mid_after got v=%b exp=0", ifa.v_o); end
    drv_a(1'b1, 32'hD, 1'b1);
    n_cmp++; if (ifa.data_o !== 32'hD) begin n_bad++; $display("FAIL mid_fresh got=%h exp=d", ifa.data_o); end
    drv_a(1'b0, 32'h0, 1'b0);
    n_cmp++; if (ifa.v_o !== 1'b0) begin n_bad++; $display("FAIL mid_idle got v=%b exp=0", ifa.v_o); end
  endtask

  task automatic test_no_bypass;
    @(negedge clk); ifb.valid_i = 1'b1; ifb.data_i = 32'h5A5A; ifb.yumi_i = 1'b0; #1;
    n_cmp++; if (ifb.v_o !== 1'b0 || ifb.ready_o !== 1'b1) begin
      n_bad++; $display("FAIL nb_enq got v=%b r=%b exp v=0 r=1", ifb.v_o, ifb.ready_o);
    end
    @(negedge clk); ifb.valid_i = 1'b0; #1;
    n_cmp++; if (ifb.v_o !== 1'b1 || ifb.data_o !== 32'h5A5A) begin
      n_bad++; $display("FAIL nb_next got v=%b d=%h exp v=1 d=5a5a", ifb.v_o, ifb.data_o);
    end
    ifb.yumi_i = 1'b1;
    @(negedge clk); ifb.yumi_i = 1'b0; #1;
    n_cmp++; if (ifb.v_o !== 1'b0) begin n_bad++; $display("FAIL nb_empty got v=%b exp=0", ifb.v_o); end
  endtask

  task automatic test_soak;
    logic [31:0] exp;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      ifa.valid_i = 1'($urandom_range(0, 1)); ifa.data_i = $urandom; ifa.yumi_i = 1'b0;
      ifb.valid_i = 1'($urandom_range(0, 1)); ifb.data_i = $urandom; ifb.yumi_i = 1'b0;
      #1;
      ifa.yumi_i = ifa.v_o & ($urandom_range(0, 3) != 0);
      ifb.yumi_i = ifb.v_o & ($urandom_range(0, 3) != 0);
      #1;
      if (ifa.valid_i && ifa.ready_o) qa.push_back(ifa.data_i);
      if (ifb.valid_i && ifb.ready_o) qb.push_back(ifb.data_i);
      if (ifa.yumi_i) begin
        n_cmp++;
        if (qa.size() == 0) begin n_bad++; $display("FAIL soak_a_extra cyc=%0d got=%h exp=none", c, ifa.data_o); end
        else begin
          exp = qa.pop_front();
          if (ifa.data_o !== exp) begin n_bad++; $display("FAIL soak_a cyc=%0d got=%h exp=%h", c, ifa.data_o, exp); end
        end
      end
      if (ifb.yumi_i) begin
        n_cmp++;
        if (qb.size() == 0) begin n_bad++; $display("FAIL soak_b_extra cyc=%0d got=%h exp=none", c, ifb.data_o); end
        else begin
          exp = qb.pop_front();
          if (ifb.data_o !== exp) begin n_bad++; $display("FAIL soak_b cyc=%0d got=%h exp=%h", c, ifb.data_o, exp); end
        end
      end
    end
    @(negedge clk);
    ifa.valid_i = 1'b0; ifa.yumi_i = 1'b0; ifb.valid_i = 1'b0; ifb.yumi_i = 1'b0;
    #1;
    n_cmp++; if (ifa.v_o !== (qa.size() != 0)) begin
      n_bad++; $display("FAIL soak_a_occ got v=%b exp=%b", ifa.v_o, (qa.size() != 0));
    end
    n_cmp++; if (ifb.v_o !== (qb.size() != 0)) begin
      n_bad++; $display("FAIL soak_b_occ got v=%b exp=%b", ifb.v_o, (qb.size() != 0));
    end
  endtask

  initial begin
    ifa.valid_i = 1'b0; ifa.data_i = '0; ifa.yumi_i = 1'b0;
    ifb.valid_i = 1'b0; ifb.data_i = '0; ifb.yumi_i = 1'b0;
    test_reset();
    test_bypass();
    test_fill_stall();
    test_simul_one();
    test_reset_mid();
    test_no_bypass();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
